// File: rtl/cpu_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : cpu_sequencer_if
// Description : Bundle of memory, decoder, ALU and register-file control
//               signals exchanged between cpu_sequencer and the CPU datapath.
// Revision    : 1.0 - initial release
// ============================================================================
interface cpu_sequencer_if #(
  parameter int PC_W = 32
);
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;
  logic [31:0]     imem_rdata;
  logic [31:0]     instr_reg;
  logic [10:0]     alu_code;
  logic [3:0]      cond_field;
  logic [23:0]     br_address;
  logic [3:0]      flags;
  logic            alu_en;
  logic            flags_we;
  logic            reg_we;
  logic            wb_sel;
  logic            lr_we;
  logic [PC_W-1:0] lr_data;
  logic            dmem_req;
  logic            dmem_we;
  logic            dmem_ack;
  logic [PC_W-1:0] pc;
  logic            retire;
  logic            illegal;

  // Sequencer side: drives control strobes, consumes acks and decoder fields.
  modport master (
    output imem_req, imem_addr, instr_reg, alu_en, flags_we, reg_we, wb_sel,
           lr_we, lr_data, dmem_req, dmem_we, pc, retire, illegal,
    input  imem_ack, imem_rdata, alu_code, cond_field, br_address, flags,
           dmem_ack
  );

  // Datapath / memory side.
  modport slave (
    input  imem_req, imem_addr, instr_reg, alu_en, flags_we, reg_we, wb_sel,
           lr_we, lr_data, dmem_req, dmem_we, pc, retire, illegal,
    output imem_ack, imem_rdata, alu_code, cond_field, br_address, flags,
           dmem_ack
  );
endinterface
`default_nettype wire

// File: rtl/cpu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : cpu_sequencer
// Description : Multi-cycle control FSM for the ARM-subset CPU. Fetches into
//               the instruction register, evaluates the condition field
//               against NZCV and sequences ALU, data memory, write-back and
//               PC update.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_sequencer #(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          reset_n,
  cpu_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_WB     = 3'd3,
    S_MEM    = 3'd4,
    S_BRANCH = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;

  logic            w_imem_req, w_alu_en, w_flags_we, w_reg_we, w_wb_sel;
  logic            w_lr_we, w_dmem_req, w_dmem_we, w_retire, w_illegal;
  logic [PC_W-1:0] w_lr_data;

  // Instruction class decode from the decoder's ALU control code.
  logic w_is_dp, w_is_cmp, w_is_br, w_is_bl, w_is_ldr, w_is_str;
  assign w_is_dp  = (bus.alu_code <= 11'd11);
  assign w_is_cmp = (bus.alu_code == 11'd8) || (bus.alu_code == 11'd9) ||
                    (bus.alu_code == 11'd10);
  assign w_is_bl  = (bus.alu_code == 11'd32);
  assign w_is_br  = (bus.alu_code == 11'd31) || w_is_bl;
  assign w_is_ldr = (bus.alu_code == 11'd41);
  assign w_is_str = (bus.alu_code == 11'd42);

  // Branch target: offset is a signed word count relative to pc + 8.
  logic [31:0]     w_off32;
  logic [PC_W-1:0] w_off, w_pc_plus4, w_br_target;
  assign w_off32     = {{6{bus.br_address[23]}}, bus.br_address, 2'b00};
  assign w_off       = PC_W'($signed(w_off32));
  assign w_pc_plus4  = pc_q + PC_W'(4);
  assign w_br_target = pc_q + PC_W'(8) + w_off;

  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'd0:    cond_pass = z;
      4'd1:    cond_pass = !z;
      4'd2:    cond_pass = cy;
      4'd3:    cond_pass = !cy;
      4'd4:    cond_pass = n;
      4'd5:    cond_pass = !n;
      4'd6:    cond_pass = v;
      4'd7:    cond_pass = !v;
      4'd8:    cond_pass = cy && !z;
      4'd9:    cond_pass = !cy || z;
      4'd10:   cond_pass = (n == v);
      4'd11:   cond_pass = (n != v);
      4'd12:   cond_pass = !z && (n == v);
      4'd13:   cond_pass = z || (n != v);
      4'd14:   cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  endfunction

  // State, PC and instruction register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  // Next-state, PC update and per-state control strobes.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    w_imem_req = 1'b0;
    w_alu_en   = 1'b0;
    w_flags_we = 1'b0;
    w_reg_we   = 1'b0;
    w_wb_sel   = 1'b0;
    w_lr_we    = 1'b0;
    w_lr_data  = '0;
    w_dmem_req = 1'b0;
    w_dmem_we  = 1'b0;
    w_retire   = 1'b0;
    w_illegal  = 1'b0;
    case (state_q)
      S_FETCH: begin
        w_imem_req = 1'b1;
        if (bus.imem_ack) begin
          instr_d = bus.imem_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (!cond_pass(bus.cond_field, bus.flags)) begin
          pc_d     = w_pc_plus4;
          w_retire = 1'b1;
          state_d  = S_FETCH;
        end else if (w_is_dp) begin
          state_d = S_EXEC;
        end else if (w_is_br) begin
          state_d = S_BRANCH;
        end else if (w_is_ldr || w_is_str) begin
          state_d = S_MEM;
        end else begin
          w_illegal = 1'b1;
          w_retire  = 1'b1;
          pc_d      = w_pc_plus4;
          state_d   = S_FETCH;
        end
      end
      S_EXEC: begin
        w_alu_en = 1'b1;
        state_d  = S_WB;
      end
      S_WB: begin
        if (w_is_ldr) begin
          w_reg_we = 1'b1;
          w_wb_sel = 1'b1;
        end else if (w_is_cmp) begin
          w_flags_we = 1'b1;
        end else begin
          w_reg_we = 1'b1;
        end
        pc_d     = w_pc_plus4;
        w_retire = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEM: begin
        w_dmem_req = 1'b1;
        w_dmem_we  = w_is_str;
        if (bus.dmem_ack) begin
          if (w_is_ldr) begin
            state_d = S_WB;
          end else begin
            pc_d     = w_pc_plus4;
            w_retire = 1'b1;
            state_d  = S_FETCH;
          end
        end
      end
      S_BRANCH: begin
        pc_d = w_br_target;
        if (w_is_bl) begin
          w_lr_we   = 1'b1;
          w_lr_data = w_pc_plus4;
        end
        w_retire = 1'b1;
        state_d  = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Fetch request is masked while reset is held so nothing is requested
  // before the sequencer is released.
  assign bus.imem_req  = w_imem_req & reset_n;
  assign bus.imem_addr = pc_q;
  assign bus.pc        = pc_q;
  assign bus.instr_reg = instr_q;
  assign bus.alu_en    = w_alu_en;
  assign bus.flags_we  = w_flags_we;
  assign bus.reg_we    = w_reg_we;
  assign bus.wb_sel    = w_wb_sel;
  assign bus.lr_we     = w_lr_we;
  assign bus.lr_data   = w_lr_data;
  assign bus.dmem_req  = w_dmem_req;
  assign bus.dmem_we   = w_dmem_we;
  assign bus.retire    = w_retire;
  assign bus.illegal   = w_illegal;

endmodule
`default_nettype wire

// File: tb/tb_cpu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_sequencer
// Description : Directed table-driven bench for cpu_sequencer with a few
//               hand-written reset and stall sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_sequencer;
  localparam int PC_W = 32;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [10:0] tb_code  = '0;
  logic [3:0]  tb_flags = '0;

  cpu_sequencer_if #(.PC_W(PC_W)) bus();

  cpu_sequencer #(.PC_W(PC_W), .RESET_PC('0)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Decoder stand-in: condition and offset come straight from the IR.
  assign bus.cond_field = bus.instr_reg[31:28];
  assign bus.br_address = bus.instr_reg[23:0];
  assign bus.alu_code   = tb_code;
  assign bus.flags      = tb_flags;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] instr;
    logic [10:0] code;
    logic [3:0]  flags;
    int          iw;     // fetch cycles until imem_ack
    int          dw;     // data cycles until dmem_ack
    int          cyc;    // expected cycles to retire
    int          alu;
    int          regwe;
    int          wbsel;
    int          fwe;
    int          lr;
    logic [31:0] lrd;
    int          dwe;
    int          dreq;
    int          ill;
    logic [31:0] npc;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [9:0] strobes();
    return {bus.imem_req, bus.alu_en, bus.flags_we, bus.reg_we, bus.wb_sel,
            bus.lr_we, bus.dmem_req, bus.dmem_we, bus.retire, bus.illegal};
  endfunction

  task automatic run_vec(input int idx, input vec_t v, input logic [31:0] start_pc);
    int cyc = 0, alu = 0, regwe = 0, wbsel = 0, fwe = 0, lr = 0;
    int dwe = 0, dreq = 0, ill = 0, excl = 0, icnt = 0, dcnt = 0;
    logic [31:0] lrd = '0;
    logic done = 1'b0;
    tb_code  = v.code;
    tb_flags = v.flags;
    bus.imem_rdata = v.instr;
    while (!done && cyc < 60) begin
      @(negedge clk);
      #1;
      cyc++;
      // flags must only matter in DECODE
      if (cyc >= v.iw + 2) tb_flags = ~v.flags;
      if (bus.imem_req) begin icnt++; bus.imem_ack = (icnt >= v.iw); end
      else bus.imem_ack = 1'b0;
      if (bus.dmem_req) begin dcnt++; bus.dmem_ack = (dcnt >= v.dw); end
      else bus.dmem_ack = 1'b0;
      if (cyc == 1) check($sformatf("v%0d_fetch_addr", idx), bus.imem_addr, start_pc);
      #1;
      alu  += int'(bus.alu_en);
      fwe  += int'(bus.flags_we);
      dwe  += int'(bus.dmem_we);
      dreq += int'(bus.dmem_req);
      ill  += int'(bus.illegal);
      if (bus.reg_we) begin regwe++; wbsel += int'(bus.wb_sel); end
      if (bus.lr_we) begin lr++; lrd = bus.lr_data; end
      if ((int'(bus.reg_we) + int'(bus.lr_we) + int'(bus.dmem_we) > 1) ||
          (bus.imem_req && bus.dmem_req)) excl++;
      if (bus.retire) done = 1'b1;
    end
    @(posedge clk);
    #1;
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    check($sformatf("v%0d_retired", idx), 32'(done), 32'd1);
    check($sformatf("v%0d_cycles", idx), cyc, v.cyc);
    check($sformatf("v%0d_alu_en", idx), alu, v.alu);
    check($sformatf("v%0d_reg_we", idx), regwe, v.regwe);
    check($sformatf("v%0d_wb_sel", idx), wbsel, v.wbsel);
    check($sformatf("v%0d_flags_we", idx), fwe, v.fwe);
    check($sformatf("v%0d_lr_we", idx), lr, v.lr);
    if (v.lr != 0) check($sformatf("v%0d_lr_data", idx), lrd, v.lrd);
    check($sformatf("v%0d_dmem_we", idx), dwe, v.dwe);
    check($sformatf("v%0d_dmem_req", idx), dreq, v.dreq);
    check($sformatf("v%0d_illegal", idx), ill, v.ill);
    check($sformatf("v%0d_exclusive", idx), excl, 0);
    check($sformatf("v%0d_next_pc", idx), bus.pc, v.npc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] pc_exp;
    int bad;
    vec_t v0;

    //          instr         code  flags   iw dw cyc alu reg wbs fwe lr lrd     dwe dreq ill npc
    vecs[0]  = '{32'hE0875006, 11'd4,  4'b0000, 1, 1, 4, 1, 1, 0, 0, 0, 32'h0,  0, 0, 0, 32'h04};
    vecs[1]  = '{32'hE1500001, 11'd8,  4'b0000, 1, 1, 4, 1, 0, 0, 1, 0, 32'h0,  0, 0, 0, 32'h08};
    vecs[2]  = '{32'h0A000002, 11'd31, 4'b0000, 1, 1, 2, 0, 0, 0, 0, 0, 32'h0,  0, 0, 0, 32'h0C};
    vecs[3]  = '{32'hE5801000, 11'd42, 4'b0000, 1, 1, 3, 0, 0, 0, 0, 0, 32'h0,  1, 1, 0, 32'h10};
    vecs[4]  = '{32'hEB000003, 11'd32, 4'b0000, 1, 1, 3, 0, 0, 0, 0, 1, 32'h14, 0, 0, 0, 32'h24};
    vecs[5]  = '{32'hE5901000, 11'd41, 4'b0000, 1, 3, 6, 0, 1, 1, 0, 0, 32'h0,  0, 3, 0, 32'h28};
    vecs[6]  = '{32'hE0000000, 11'd20, 4'b0000, 1, 1, 2, 0, 0, 0, 0, 0, 32'h0,  0, 0, 1, 32'h2C};
    vecs[7]  = '{32'hA0000000, 11'd4,  4'b1000, 1, 1, 2, 0, 0, 0, 0, 0, 32'h0,  0, 0, 0, 32'h30};
    vecs[8]  = '{32'hC0000000, 11'd0,  4'b1001, 1, 1, 4, 1, 1, 0, 0, 0, 32'h0,  0, 0, 0, 32'h34};
    vecs[9]  = '{32'hF0000000, 11'd4,  4'b0000, 1, 1, 2, 0, 0, 0, 0, 0, 32'h0,  0, 0, 0, 32'h38};
    vecs[10] = '{32'hEAFFFFFE, 11'd31, 4'b0000, 1, 1, 3, 0, 0, 0, 0, 0, 32'h0,  0, 0, 0, 32'h38};
    vecs[11] = '{32'h80000000, 11'd9,  4'b0010, 3, 1, 6, 1, 0, 0, 1, 0, 32'h0,  0, 0, 0, 32'h3C};
    vecs[12] = '{32'h90000000, 11'd4,  4'b0010, 1, 1, 2, 0, 0, 0, 0, 0, 32'h0,  0, 0, 0, 32'h40};

    bus.imem_ack   = 1'b0;
    bus.dmem_ack   = 1'b0;
    bus.imem_rdata = '0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("reset_strobes", 32'(strobes()), 32'd0);
    check("reset_pc", bus.pc, 32'h0);
    check("reset_ir", bus.instr_reg, 32'h0);
    check("reset_lr_data", bus.lr_data, 32'h0);
    reset_n = 1'b1;
    #1;
    check("first_imem_req", 32'(bus.imem_req), 32'd1);
    check("first_imem_addr", bus.imem_addr, 32'h0);

    // Directed instruction table
    pc_exp = 32'h0;
    for (int i = 0; i < 13; i++) begin
      run_vec(i, vecs[i], pc_exp);
      pc_exp = vecs[i].npc;
    end

    // Reset pulsed in the middle of a stalled LDR
    tb_code  = 11'd41;
    tb_flags = 4'b0000;
    bus.imem_rdata = 32'hE5901000;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      #1;
      bus.imem_ack = bus.imem_req;
      bus.dmem_ack = 1'b0;
      #1;
      if (c == 3) check("midmem_dmem_req", 32'(bus.dmem_req), 32'd1);
    end
    reset_n = 1'b0;
    #1;
    check("midmem_reset_strobes", 32'(strobes()), 32'd0);
    check("midmem_reset_pc", bus.pc, 32'h0);
    check("midmem_reset_ir", bus.instr_reg, 32'h0);
    bus.imem_ack = 1'b0;
    bad = 0;
    repeat (2) begin
      @(negedge clk);
      #1;
      if (bus.reg_we || bus.dmem_we || bus.dmem_req) bad++;
    end
    reset_n = 1'b1;
    // Fetch held off: request stays up and pc does not move
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      if (bus.reg_we || bus.dmem_we || bus.dmem_req) bad++;
      if (!bus.imem_req || bus.imem_addr !== 32'h0) bad++;
    end
    check("post_reset_stall", bad, 0);
    v0 = vecs[0];
    run_vec(13, v0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Multi-cycle control FSM for the EE469 ARM-subset CPU.
- Fetches from instruction memory and holds the instruction register that feeds instruction_decoder.
- Evaluates the condition field against the NZCV flags and sequences the ALU, data memory, register-file writes and PC update.
- Sits between the memories, instruction_decoder, the register file and the ALU in cpu top.

Parameters:
- PC_W, 32, width of PC and memory addresses.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- imem_req  out  1  instruction fetch request
- imem_addr  out  PC_W  fetch address (= pc)
- imem_ack  in  1  fetch data valid this cycle
- imem_rdata  in  32  fetched instruction
- instr_reg  out  32  latched instruction, drives instruction_set of the decoder
- alu_code  in  11  ALUCtl_code from the decoder
- cond_field  in  4  condition field from the decoder
- br_address  in  24  branch offset from the decoder
- flags  in  4  {N,Z,C,V} from the flags register
- alu_en  out  1  ALU operation strobe
- flags_we  out  1  flags register write
- reg_we  out  1  register-file write to rd
- wb_sel  out  1  write-back source: 0 = ALU, 1 = memory
- lr_we  out  1  write R14 with lr_data
- lr_data  out  PC_W  return address
- dmem_req  out  1  data memory request
- dmem_we  out  1  data memory write (STR)
- dmem_ack  in  1  data memory done
- pc  out  PC_W  program counter
- retire  out  1  one-cycle pulse per completed instruction, including annulled ones
- illegal  out  1  one-cycle pulse when the decoded code is unrecognised

Behaviour:
- Reset (async, reset_n=0):
  - state=FETCH, pc=RESET_PC, instr_reg=0.
  - All strobes = 0: imem_req, alu_en, flags_we, reg_we, wb_sel, lr_we, dmem_req, dmem_we, retire, illegal.
  - lr_data=0.
  - Reset mid-operation abandons the instruction; no write strobes are asserted after reset.
- States: FETCH, DECODE, EXEC, WB, MEM, BRANCH.
- FETCH:
  - imem_req=1 until imem_ack.
  - On ack: instr_reg <= imem_rdata, go to DECODE.
  - A held-off ack stalls indefinitely; pc is stable.
- DECODE: one cycle; decoder outputs are valid combinationally from instr_reg.
  - Evaluate cond_field:
    - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V.
    - HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V).
    - AL 1; 1111 never.
  - Condition false: pc += 4, retire=1, go to FETCH.
  - alu_code 0–11: go to EXEC.
  - alu_code 31 or 32: go to BRANCH.
  - alu_code 41 or 42: go to MEM.
  - Any other code: illegal=1, retire=1, pc += 4, go to FETCH.
- EXEC: alu_en=1 for exactly one cycle, then WB.
- WB (one cycle):
  - Codes 8, 9, 10 (CMP, TST, TEQ): flags_we=1, reg_we=0.
  - Other data-processing codes: reg_we=1, wb_sel=0.
  - Arriving from LDR: reg_we=1, wb_sel=1.
  - Then pc += 4, retire=1, go to FETCH.
- MEM:
  - dmem_req=1, and dmem_we=1 if code is 42, held until dmem_ack.
  - Ack with LDR: go to WB.
  - Ack with STR: pc += 4, retire=1, go to FETCH.
- BRANCH (one cycle):
  - pc <= pc + 8 + (sign_extend(br_address) << 2), truncated to PC_W with modulo wrap.
  - If code is 32: lr_we=1, lr_data = pc + 4 (pre-update pc).
  - retire=1, go to FETCH.
- Arithmetic rules:
  - All pc updates are registered and take effect on the cycle leaving the state.
  - pc + 4 wraps modulo 2^PC_W.
- Latency in cycles, with zero-wait memories (ack in the first request cycle):
  - DP = 4 (FETCH, DECODE, EXEC, WB).
  - LDR = 4 (FETCH, DECODE, MEM, WB).
  - STR = 3.
  - B/BL = 3.
  - Annulled = 2.
- Strobe rules:
  - All strobes are Moore outputs of the current state, at most one cycle each, except req, which is held while waiting.
  - Only one of reg_we, lr_we, dmem_we may be high in any cycle.
  - imem_req and dmem_req are never high together.
- flags are sampled only in DECODE; later changes do not affect the current instruction.

Test Plan:
- Reset then fetch: hold reset_n=0, release, imem_ack=1 always → imem_addr=0 and imem_req=1 in the first cycle; all strobes 0 during reset.
- ADD 0xE0875006 → reg_we=1, wb_sel=0 in cycle 4; retire pulse; next imem_addr=4.
- CMP sets flags, then BEQ not taken: code 8 → flags_we=1, reg_we=0. Then flags Z=0 with 0x0A000002 → annulled in 2 cycles, pc+=4, no alu_en.
- BL 0xEB000003 at pc=0x10 → lr_we=1, lr_data=0x14, pc=0x24. Branch offset 0xFFFFFE at pc=0x20 → pc=0x20.
- LDR with dmem_ack delayed 3 cycles → dmem_req held 3 cycles, dmem_we=0, then reg_we=1 with wb_sel=1. STR → dmem_we=1, no reg_we.
- Unknown code (e.g. 20), plus reset_n pulsed low mid-MEM → illegal pulse with pc+=4; after the reset pulse, pc=RESET_PC and no dmem_we/reg_we are seen.
